// File: rtl/histo_scan_ctrl.sv
// histo_scan_ctrl: per-frame readout of the luminance histogram RAM into the
// top-ten bin selector. Scans every bin as one contiguous valid window, waits
// for the selector to settle, latches its enable decision and, optionally,
// wipes the histogram RAM for the next frame.
//
// Build option: define HISTO_CLR_EN to include the CLEAR phase. Without it the
// FSM returns to IDLE straight after LATCH and ram_wr_en / ram_wr_addr stay 0.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for frame_done
// READ   | one RAM read per cycle, addresses 0..BINS-1
// DRAIN  | RD_LAT cycles while the last reads emerge from the RAM
// SETTLE | SETTLE cycles with the selector inputs quiet
// LATCH  | one cycle: result_enn captured from sel_enn, result_vld pulses
// CLEAR  | one RAM write per cycle, addresses 0..BINS-1 (HISTO_CLR_EN only)
//
// Phase lengths are timed by a down-counter loaded with (length-1) and
// compared against zero. It is ADDR_W+1 bits wide so BINS = 2^ADDR_W still
// has an unambiguous terminal count; RD_LAT and SETTLE must fit in it too.

module histo_scan_ctrl #(
    parameter int BINS   = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_done,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic              sel_vld,
    output logic [DATA_W-1:0] sel_data,
    output logic [ADDR_W-1:0] sel_addr,
    input  logic              sel_enn,
    output logic              result_vld,
    output logic              result_enn,
    output logic              busy,
    output logic              overrun
);

    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0] BINS_TC   = CNT_W'(BINS - 1);
    localparam logic [CNT_W-1:0] DRAIN_TC  = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_SETTLE,
        ST_LATCH,
        ST_CLEAR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [RD_LAT-1:0] vld_sr;

    // Sequencer: all control outputs are registered and change with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            result_vld  <= 1'b0;
            result_enn  <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            result_vld <= 1'b0;

            // A frame_done that finds us anywhere but IDLE is dropped; this
            // includes the final LATCH/CLEAR cycle, since state is not yet IDLE.
            if (frame_done && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (frame_done) begin
                        state       <= ST_READ;
                        cnt         <= BINS_TC;
                        ram_rd_en   <= 1'b1;
                        ram_rd_addr <= '0;
                        busy        <= 1'b1;
                    end
                end

                ST_READ: begin
                    if (cnt == '0) begin
                        state     <= ST_DRAIN;
                        cnt       <= DRAIN_TC;
                        ram_rd_en <= 1'b0;
                    end else begin
                        cnt         <= cnt - 1'b1;
                        ram_rd_addr <= ram_rd_addr + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (cnt == '0) begin
                        state <= ST_SETTLE;
                        cnt   <= SETTLE_TC;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_SETTLE: begin
                    // result_enn and result_vld are loaded together so the
                    // pulse and the new decision appear in the same cycle.
                    if (cnt == '0) begin
                        state      <= ST_LATCH;
                        result_vld <= 1'b1;
                        result_enn <= sel_enn;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_LATCH: begin
`ifdef HISTO_CLR_EN
                    state       <= ST_CLEAR;
                    cnt         <= BINS_TC;
                    ram_wr_en   <= 1'b1;
                    ram_wr_addr <= '0;
`else
                    state <= ST_IDLE;
                    busy  <= 1'b0;
`endif
                end

`ifdef HISTO_CLR_EN
                ST_CLEAR: begin
                    if (cnt == '0) begin
                        state       <= ST_IDLE;
                        ram_wr_en   <= 1'b0;
                        ram_wr_addr <= '0;
                        busy        <= 1'b0;
                    end else begin
                        cnt         <= cnt - 1'b1;
                        ram_wr_addr <= ram_wr_addr + 1'b1;
                    end
                end
`endif

                default: begin
                    state     <= ST_IDLE;
                    ram_rd_en <= 1'b0;
                    ram_wr_en <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Valid follows the read strobe through the RAM latency, giving a
    // gap-free window of exactly BINS beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= ram_rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    assign sel_vld  = vld_sr[RD_LAT-1];
    assign sel_data = ram_rd_data;

    // The selector registers sel_addr once itself, so the address runs one
    // cycle ahead of the data: RD_LAT-1 stages here.
    generate
        if (RD_LAT == 1) begin : g_addr_direct
            assign sel_addr = ram_rd_addr;
        end else begin : g_addr_pipe
            logic [RD_LAT-2:0][ADDR_W-1:0] addr_sr;

            // Address delay line matching the RAM latency minus one.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    addr_sr <= '0;
                end else begin
                    addr_sr[0] <= ram_rd_addr;
                    for (int i = 1; i < RD_LAT - 1; i++) begin
                        addr_sr[i] <= addr_sr[i-1];
                    end
                end
            end

            assign sel_addr = addr_sr[RD_LAT-2];
        end
    endgenerate

endmodule

// File: tb/tb_histo_scan_ctrl.sv
// Bench for histo_scan_ctrl: two instances (RD_LAT=1/SETTLE=4 and
// RD_LAT=3/SETTLE=2) share clock, reset and frame_done. Each has its own RAM
// and top-ten selector model. A frame-level model predicts every output on
// every cycle from the frame start time; directed literal checks pin it.

module tb_histo_scan_ctrl;

    localparam int BINS = 256;
`ifdef HISTO_CLR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        frame_done;
    logic        rd_en      [2];
    logic [7:0]  rd_addr    [2];
    logic [31:0] rd_data    [2];
    logic        wr_en      [2];
    logic [7:0]  wr_addr    [2];
    logic        sel_vld    [2];
    logic [31:0] sel_data   [2];
    logic [7:0]  sel_addr   [2];
    logic        sel_enn    [2];
    logic        result_vld [2];
    logic        result_enn [2];
    logic        busy       [2];
    logic        overrun    [2];

    int n_chk;
    int n_fail;
    int cyc;

    logic [31:0] mem [2][BINS];
    logic [31:0] p0 [2];
    logic [31:0] p1 [2];
    logic [31:0] p2 [2];

    int t_start [2];
    bit m_ovr   [2];
    bit m_enn   [2];
    bit m_dec   [2];
    int snap    [2][BINS];
    int sbuf    [2][BINS];
    int scnt    [2];

    histo_scan_ctrl #(.BINS(BINS), .ADDR_W(8), .DATA_W(32), .RD_LAT(1), .SETTLE(4)) u_dut0 (
        .clk(clk), .rst(rst), .frame_done(frame_done),
        .ram_rd_en(rd_en[0]), .ram_rd_addr(rd_addr[0]), .ram_rd_data(rd_data[0]),
        .ram_wr_en(wr_en[0]), .ram_wr_addr(wr_addr[0]),
        .sel_vld(sel_vld[0]), .sel_data(sel_data[0]), .sel_addr(sel_addr[0]),
        .sel_enn(sel_enn[0]), .result_vld(result_vld[0]), .result_enn(result_enn[0]),
        .busy(busy[0]), .overrun(overrun[0])
    );

    histo_scan_ctrl #(.BINS(BINS), .ADDR_W(8), .DATA_W(32), .RD_LAT(3), .SETTLE(2)) u_dut1 (
        .clk(clk), .rst(rst), .frame_done(frame_done),
        .ram_rd_en(rd_en[1]), .ram_rd_addr(rd_addr[1]), .ram_rd_data(rd_data[1]),
        .ram_wr_en(wr_en[1]), .ram_wr_addr(wr_addr[1]),
        .sel_vld(sel_vld[1]), .sel_data(sel_data[1]), .sel_addr(sel_addr[1]),
        .sel_enn(sel_enn[1]), .result_vld(result_vld[1]), .result_enn(result_enn[1]),
        .busy(busy[1]), .overrun(overrun[1])
    );

    assign rd_data[0] = p0[0];
    assign rd_data[1] = p2[1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Histogram RAM models: registered read port, 1 or 3 cycles latency.
    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                p2[k] = p1[k];
                p1[k] = p0[k];
                if (rd_en[k]) p0[k] = mem[k][rd_addr[k]];
                if (wr_en[k]) mem[k][wr_addr[k]] = 32'd0;
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint top10(input int a [BINS]);
        int best [10];
        longint s;
        for (int j = 0; j < 10; j++) best[j] = 0;
        for (int i = 0; i < BINS; i++) begin
            int v;
            v = a[i];
            for (int j = 0; j < 10; j++) begin
                if (v > best[j]) begin
                    int t;
                    t = best[j];
                    best[j] = v;
                    v = t;
                end
            end
        end
        s = 0;
        for (int j = 0; j < 10; j++) s += best[j];
        return s;
    endfunction

    function automatic bit in_win(input int c, input int a, input int b);
        return (c >= a) && (c <= b);
    endfunction

    // Frame model, per-cycle compare, and top-ten selector models.
    initial begin
        for (int k = 0; k < 2; k++) begin
            t_start[k] = -1;
            m_ovr[k] = 1'b0;
            m_enn[k] = 1'b0;
            m_dec[k] = 1'b0;
            scnt[k] = 0;
            sel_enn[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int c, T, L, S, r0, r1, v0, v1, lat, cl0, cl1, e_end;
                bit act, e_busy, e_rd, e_vld, e_wr;
                string sfx;
                c = cyc;
                L = (k == 0) ? 1 : 3;
                S = (k == 0) ? 4 : 2;
                sfx = $sformatf("%0d@%0d", k, c);
                if (!rst) begin
                    t_start[k] = -1;
                    m_ovr[k] = 1'b0;
                    m_enn[k] = 1'b0;
                end
                T   = t_start[k];
                act = (T >= 0);
                r0  = T + 1;
                r1  = T + BINS;
                v0  = r0 + L;
                v1  = r1 + L;
                lat = v1 + S + 1;
                cl0 = lat + 1;
                cl1 = lat + BINS;
                e_end = CLR ? cl1 : lat;
                if (act && c == lat) m_enn[k] = m_dec[k];

                e_busy = act && in_win(c, r0, e_end);
                e_rd   = act && in_win(c, r0, r1);
                e_vld  = act && in_win(c, v0, v1);
                e_wr   = CLR && act && in_win(c, cl0, cl1);

                chk({"busy", sfx}, busy[k], e_busy);
                chk({"rd_en", sfx}, rd_en[k], e_rd);
                chk({"sel_vld", sfx}, sel_vld[k], e_vld);
                chk({"res_vld", sfx}, result_vld[k], act && c == lat);
                chk({"res_enn", sfx}, result_enn[k], m_enn[k]);
                chk({"overrun", sfx}, overrun[k], m_ovr[k]);
                chk({"wr_en", sfx}, wr_en[k], e_wr);
                if (e_rd) chk({"rd_addr", sfx}, rd_addr[k], c - r0);
                if (e_vld) chk({"sel_data", sfx}, sel_data[k], snap[k][c - v0]);
                if (act && in_win(c, v0 - 1, v1 - 1)) chk({"sel_addr", sfx}, sel_addr[k], c - (v0 - 1));
                if (e_wr) chk({"wr_addr", sfx}, wr_addr[k], c - cl0);
                if (!CLR) chk({"wr_addr", sfx}, wr_addr[k], 0);
                if (!rst) begin
                    chk({"rst_rd_addr", sfx}, rd_addr[k], 0);
                    chk({"rst_sel_addr", sfx}, sel_addr[k], 0);
                end

                if (rst && frame_done) begin
                    if (e_busy) begin
                        m_ovr[k] = 1'b1;
                    end else begin
                        int tmp [BINS];
                        t_start[k] = c;
                        for (int i = 0; i < BINS; i++) begin
                            snap[k][i] = int'(mem[k][i]);
                            tmp[i] = snap[k][i];
                        end
                        m_dec[k] = (top10(tmp) >= 64'd7000);
                    end
                end

                // Selector: gather the window, decide once it closes.
                if (!rst) begin
                    scnt[k] = 0;
                end else if (sel_vld[k]) begin
                    if (scnt[k] < BINS) sbuf[k][scnt[k]] = int'(sel_data[k]);
                    scnt[k]++;
                end else if (scnt[k] > 0) begin
                    int tmp2 [BINS];
                    for (int i = 0; i < BINS; i++) tmp2[i] = (i < scnt[k]) ? sbuf[k][i] : 0;
                    sel_enn[k] = (top10(tmp2) >= 64'd7000);
                    scnt[k] = 0;
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int mode);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < BINS; i++)
                mem[k][i] = (mode == 0) ? ((i >= 246) ? 32'd1000 : 32'(i)) : 32'd10;
    endtask

    task automatic pulse_fd(input int c);
        wait_cyc(c);
        frame_done = 1'b1;
        wait_cyc(c + 1);
        frame_done = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b0;
        frame_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            p0[k] = '0;
            p1[k] = '0;
            p2[k] = '0;
        end

        wait_cyc(1);
        @(negedge clk);
        chk("lit_rst_busy", busy[0], 0);
        chk("lit_rst_ovr", overrun[0], 0);
        chk("lit_rst_enn", result_enn[0], 0);
        chk("lit_rst_rden", rd_en[0], 0);
        wait_cyc(3);
        rst = 1'b1;

        // Frame 1: bin[i]=i, bins 246..255 = 1000 -> decision 1.
        load(0);
        pulse_fd(10);
        wait_cyc(11);  @(negedge clk);
        chk("lit_f1_rden", rd_en[0], 1);
        chk("lit_f1_addr0", rd_addr[0], 0);
        wait_cyc(12);  @(negedge clk);
        chk("lit_f1_vld0", sel_vld[0], 1);
        chk("lit_f1_data0", sel_data[0], 0);
        wait_cyc(13);  @(negedge clk);
        chk("lit_f1_vld1_pre", sel_vld[1], 0);
        wait_cyc(14);  @(negedge clk);
        chk("lit_f1_vld1", sel_vld[1], 1);
        chk("lit_f1_data1", sel_data[1], 0);
        wait_cyc(266); @(negedge clk);
        chk("lit_f1_addr255", rd_addr[0], 255);
        wait_cyc(267); @(negedge clk);
        chk("lit_f1_data255", sel_data[0], 1000);
        wait_cyc(268); @(negedge clk);
        chk("lit_f1_vld0_fall", sel_vld[0], 0);
        wait_cyc(270); @(negedge clk);
        chk("lit_f1_vld1_fall", sel_vld[1], 0);
`ifdef HISTO_CLR_EN
        wait_cyc(272); @(negedge clk);
        chk("lit_f1_rv0", result_vld[0], 1);
        chk("lit_f1_enn0", result_enn[0], 1);
        chk("lit_f1_rv1", result_vld[1], 1);
        chk("lit_f1_enn1", result_enn[1], 1);
        wait_cyc(273); @(negedge clk);
        chk("lit_f1_wren", wr_en[0], 1);
        chk("lit_f1_wra0", wr_addr[0], 0);
        chk("lit_f1_rden_off", rd_en[0], 0);
        wait_cyc(528);
        frame_done = 1'b1;
        @(negedge clk);
        chk("lit_f1_wra255", wr_addr[0], 255);
        chk("lit_f1_ovr_pre", overrun[0], 0);
        wait_cyc(529);
        frame_done = 1'b0;
        @(negedge clk);
        chk("lit_f1_busy_off", busy[0], 0);
        chk("lit_f1_ovr_post", overrun[0], 1);
`else
        wait_cyc(272);
        frame_done = 1'b1;
        @(negedge clk);
        chk("lit_f1_rv0", result_vld[0], 1);
        chk("lit_f1_enn0", result_enn[0], 1);
        chk("lit_f1_rv1", result_vld[1], 1);
        chk("lit_f1_enn1", result_enn[1], 1);
        chk("lit_f1_ovr_pre", overrun[0], 0);
        wait_cyc(273);
        frame_done = 1'b0;
        @(negedge clk);
        chk("lit_f1_busy_off", busy[0], 0);
        chk("lit_f1_ovr_post", overrun[0], 1);
        chk("lit_f1_wren", wr_en[0], 0);
`endif

        // Frame 2: no reload; cleared RAM reads back zeros when clearing is built in.
        pulse_fd(600);
        wait_cyc(862); @(negedge clk);
`ifdef HISTO_CLR_EN
        chk("lit_f2_enn", result_enn[0], 0);
`else
        chk("lit_f2_enn", result_enn[0], 1);
`endif

        // Frame 3: asynchronous reset in the middle of READ.
        load(0);
        pulse_fd(1200);
        wait_cyc(1340);
        #1 rst = 1'b0;
        #1;
        chk("lit_rst_mid_rden0", rd_en[0], 0);
        chk("lit_rst_mid_busy0", busy[0], 0);
        chk("lit_rst_mid_addr0", rd_addr[0], 0);
        chk("lit_rst_mid_ovr0", overrun[0], 0);
        chk("lit_rst_mid_enn0", result_enn[0], 0);
        chk("lit_rst_mid_busy1", busy[1], 0);
        chk("lit_rst_mid_vld1", sel_vld[1], 0);
        wait_cyc(1345);
        rst = 1'b1;

        // Frame 4: restart from address 0; overlapping frame_done sets overrun.
        load(0);
        pulse_fd(1800);
        wait_cyc(1801); @(negedge clk);
        chk("lit_f4_addr0", rd_addr[0], 0);
        pulse_fd(1890);
        @(negedge clk);
        chk("lit_f4_ovr", overrun[0], 1);
        wait_cyc(2061); @(negedge clk);
        chk("lit_f4_enn_pre", result_enn[0], 0);
        wait_cyc(2062); @(negedge clk);
        chk("lit_f4_enn", result_enn[0], 1);
        chk("lit_f4_rv", result_vld[0], 1);

        // Frame 5: flat histogram -> decision 0.
        load(1);
        pulse_fd(2400);
        wait_cyc(2662); @(negedge clk);
        chk("lit_f5_enn0", result_enn[0], 0);
        chk("lit_f5_enn1", result_enn[1], 0);

        wait_cyc(3000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/histo_scan_ctrl.md
Name: histo_scan_ctrl

Overview:
Sequencer that drives the per-frame readout of the 256-bin luminance histogram RAM into the top-ten bin selector. After a frame completes it scans every bin, producing a contiguous valid window whose falling edge triggers the selector's capture. It waits for the selector to settle, latches the selector's enable decision as the frame result, and optionally clears the histogram RAM for the next frame.

Parameters:
BINS, 256, number of histogram bins scanned per frame
ADDR_W, 8, bin address width; must satisfy 2^ADDR_W >= BINS
DATA_W, 32, bin count width
RD_LAT, 1, histogram RAM read latency in cycles (1..3)
SETTLE, 4, cycles to wait after the valid window ends before sampling sel_enn (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
frame_done  in  1  single-cycle pulse from the histogram builder when a frame's counts are final
ram_rd_en  out  1  histogram RAM read strobe
ram_rd_addr  out  ADDR_W  histogram RAM read address
ram_rd_data  in  DATA_W  histogram RAM read data, valid RD_LAT cycles after ram_rd_en
ram_wr_en  out  1  histogram RAM write strobe (clear phase)
ram_wr_addr  out  ADDR_W  histogram RAM write address
sel_vld  out  1  valid to selector (po_histo_vld)
sel_data  out  DATA_W  bin count to selector (po_histo_data)
sel_addr  out  ADDR_W  bin address to selector (rd_addr); selector registers it once
sel_enn  in  1  selector threshold decision
result_vld  out  1  one-cycle pulse: result_enn updated
result_enn  out  1  latched frame decision
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky: frame_done arrived while busy

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; counters 0; overrun cleared. Takes effect immediately, including mid-scan or mid-clear; the RAM is left as-is.
- States: IDLE, READ, DRAIN, SETTLE, LATCH, CLEAR.
- IDLE: frame_done=1 -> READ next cycle; otherwise hold.
- READ: bin counter starts at 0. ram_rd_en=1, ram_rd_addr=counter, counter+1 every cycle. The state lasts exactly BINS cycles, then moves to DRAIN.
- sel_vld is ram_rd_en delayed RD_LAT cycles.
- sel_data = ram_rd_data, unregistered pass-through; the RAM output is registered.
- sel_addr is ram_rd_addr delayed RD_LAT-1 cycles, so the selector's internal one-cycle register aligns the address with sel_data.
- sel_vld is high for exactly BINS contiguous cycles; no gaps.
- DRAIN: lasts RD_LAT cycles, until the last valid beat has been presented. sel_vld falls on the cycle after the last beat, then -> SETTLE.
- SETTLE: counts SETTLE cycles, then -> LATCH. No selector inputs change; sel_vld=0, sel_data holds last value.
- LATCH (1 cycle): result_enn<=sel_enn, result_vld=1 for this cycle only. Next state is CLEAR when HISTO_CLR_EN is defined, else IDLE.
- CLEAR: ram_wr_en=1, ram_wr_addr=0..BINS-1, one address per cycle, BINS cycles, then -> IDLE. The write data port is owned by the builder, which drives 0 whenever ram_wr_en is high.
- Timing, frame_done at cycle T with RD_LAT=1, SETTLE=4:
  - ram_rd_en high T+1..T+256.
  - sel_vld high T+2..T+257.
  - LATCH at T+262; result_vld pulses at T+262.
  - With clear: CLEAR T+263..T+518, busy high T+1..T+518.
  - Without clear: busy high T+1..T+262.
- frame_done while busy (including the LATCH cycle): ignored and overrun set. It is cleared only by reset.
- frame_done in the same cycle the FSM returns to IDLE (last CLEAR or LATCH cycle) counts as busy, so it is ignored and overrun is set.
- ram_rd_en and ram_wr_en are never high in the same cycle.
- result_enn holds its value between frames; it is 0 until the first LATCH.
- Counters use ADDR_W+1 bits so BINS=2^ADDR_W terminates without wrap ambiguity.

Optional Feature:
HISTO_CLR_EN
- Defined: the CLEAR state is present and zeroes all BINS RAM locations after each LATCH.
- Undefined: LATCH -> IDLE directly; ram_wr_en and ram_wr_addr are tied to 0, and the builder is responsible for clearing.

Test Plan:
- Reset, then frame_done at T=10 with RAM preloaded bin[i]=i -> ram_rd_addr 0..255 on cycles 11..266; sel_vld high 12..267 with sel_data=0..255; sel_addr registered once equals the sel_data bin.
- Selector model drives sel_enn=1 when sum of the 10 largest bins is >= 7000; bins 246..255 = 1000 each -> result_vld pulse at cycle 272, result_enn=1. Next frame all bins=10 -> result_enn=0.
- HISTO_CLR_EN defined -> ram_wr_en high 256 cycles, addresses 0..255, busy falls at cycle 528; a read-back scan returns all zeros. Undefined -> ram_wr_en never asserts, busy falls at cycle 272.
- Second frame_done at cycle 100 during READ -> ignored, overrun=1, scan unaffected. frame_done on the last busy cycle -> ignored, overrun=1.
- rst asserted at cycle 150 mid-READ -> all outputs 0 immediately, state IDLE. After release, a new frame_done restarts at address 0 and result_enn=0 until the next LATCH.
- RD_LAT=3, SETTLE=2 -> sel_vld lags ram_rd_en by 3 cycles, still 256 contiguous beats, LATCH 2 cycles after sel_vld falls.
